// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, sequenced LSB-first
// across a WIDTH-bit word. The result, carry-out and signed overflow are held until the next operation.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] ra, rb, acc, acc_nx;
   logic [CNT_W-1:0] cnt;
   logic             c, s, c_nx, last, accept;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (z & (x ^ y));
   endfunction

   assign s      = ra[0] ^ rb[0] ^ c;
   assign c_nx   = maj3(ra[0], rb[0], c);
   assign acc_nx = (acc >> 1) | (WIDTH'(s) << (WIDTH - 1));
   assign last   = (cnt == CNT_W'(WIDTH - 1));
   assign accept = start && (state != SHIFT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? SHIFT : IDLE;
         SHIFT:   state_nx = last ? DONE : SHIFT;
         DONE:    state_nx = start ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

   // Datapath: the final bit writes the result registers directly, so they
   // change exactly on the edge that enters DONE. The carry into the MSB is
   // the current c on that last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ra   <= '0;
         rb   <= '0;
         c    <= 1'b0;
         acc  <= '0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else if (accept) begin
         ra  <= a;
         rb  <= b;
         c   <= cin;
         acc <= '0;
         cnt <= '0;
      end else if (state == SHIFT) begin
         ra  <= ra >> 1;
         rb  <= rb >> 1;
         c   <= c_nx;
         acc <= acc_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            sum  <= acc_nx;
            cout <= c_nx;
            ovf  <= c ^ c_nx;
         end
      end
   end

endmodule
